// File: rtl/ex_forward_unit.sv
// EX-stage result path: EX/MEM and MEM/WB result registers, ALU operand forwarding,
// ID-stage register-file bypass, load-use stall detection and register-file write port.
module ex_forward_unit (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic [31:0] id_read_data1_i,
    input  logic [31:0] id_read_data2_i,
    input  logic [4:0]  ex_rs_i,
    input  logic [4:0]  ex_rt_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_reg_write_i,
    input  logic        ex_mem_read_i,
    input  logic [31:0] ex_read_data1_i,
    input  logic [31:0] ex_read_data2_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic [31:0] mem_read_data_i,
    input  logic        flush_i,
    output logic [31:0] alu_in_a_o,
    output logic [31:0] alu_in_b_o,
    output logic [31:0] id_op_a_o,
    output logic [31:0] id_op_b_o,
    output logic        stall_o,
    output logic        wb_reg_write_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic [15:0] stall_count_o
);

    logic [4:0]  m_rd_q, m_rd_d;
    logic        m_reg_write_q, m_reg_write_d;
    logic        m_mem_read_q, m_mem_read_d;
    logic [31:0] m_alu_result_q, m_alu_result_d;
    logic [4:0]  w_rd_q, w_rd_d;
    logic        w_reg_write_q, w_reg_write_d;
    logic [31:0] w_data_q, w_data_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        stall;

    logic [1:0][4:0]  ex_src, id_src;
    logic [1:0][31:0] ex_raw, id_raw, alu_in, id_op;

    assign ex_src = {ex_rt_i, ex_rs_i};
    assign ex_raw = {ex_read_data2_i, ex_read_data1_i};
    assign id_src = {id_rt_i, id_rs_i};
    assign id_raw = {id_read_data2_i, id_read_data1_i};

    // A load sitting in EX/MEM has no data yet, so only ALU results forward from there.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic m_hit, w_hit, id_hit;
            assign m_hit  = m_reg_write_q && !m_mem_read_q && (m_rd_q != 5'd0) && (m_rd_q == ex_src[gi]);
            assign w_hit  = w_reg_write_q && (w_rd_q != 5'd0) && (w_rd_q == ex_src[gi]);
            assign id_hit = w_reg_write_q && (w_rd_q != 5'd0) && (w_rd_q == id_src[gi]);
            assign alu_in[gi] = m_hit ? m_alu_result_q : (w_hit ? w_data_q : ex_raw[gi]);
            assign id_op[gi]  = id_hit ? w_data_q : id_raw[gi];
        end
    endgenerate

    // Flush kills the load, so it can never also demand a stall.
    assign stall = ex_mem_read_i && ex_reg_write_i && (ex_rd_i != 5'd0)
                && ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i)) && !flush_i;

    always_comb begin
        m_rd_d         = ex_rd_i;
        m_reg_write_d  = ex_reg_write_i && !flush_i;
        m_mem_read_d   = ex_mem_read_i && !flush_i;
        m_alu_result_d = ex_alu_result_i;
        w_rd_d         = m_rd_q;
        w_reg_write_d  = m_reg_write_q;
        w_data_d       = m_mem_read_q ? mem_read_data_i : m_alu_result_q;
        stall_count_d  = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            m_rd_q         <= 5'd0;
            m_reg_write_q  <= 1'b0;
            m_mem_read_q   <= 1'b0;
            m_alu_result_q <= 32'd0;
            w_rd_q         <= 5'd0;
            w_reg_write_q  <= 1'b0;
            w_data_q       <= 32'd0;
            stall_count_q  <= 16'd0;
        end else begin
            m_rd_q         <= m_rd_d;
            m_reg_write_q  <= m_reg_write_d;
            m_mem_read_q   <= m_mem_read_d;
            m_alu_result_q <= m_alu_result_d;
            w_rd_q         <= w_rd_d;
            w_reg_write_q  <= w_reg_write_d;
            w_data_q       <= w_data_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign alu_in_a_o     = alu_in[0];
    assign alu_in_b_o     = alu_in[1];
    assign id_op_a_o      = id_op[0];
    assign id_op_b_o      = id_op[1];
    assign stall_o        = stall;
    assign wb_reg_write_o = w_reg_write_q;
    assign wb_rd_o        = w_rd_q;
    assign wb_data_o      = w_data_q;
    assign stall_count_o  = stall_count_q;

endmodule

// File: tb/tb_ex_forward_unit.sv
// Bench for ex_forward_unit: directed vector table, randomized run against a
// producer-history model, and a stall-counter saturation run.
module tb_ex_forward_unit;

    logic        clock, reset, flush;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd;
    logic [31:0] id_read_data1, id_read_data2, ex_read_data1, ex_read_data2;
    logic [31:0] ex_alu_result, mem_read_data;
    logic        ex_reg_write, ex_mem_read;
    logic [31:0] alu_in_a, alu_in_b, id_op_a, id_op_b, wb_data;
    logic        stall, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [15:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    ex_forward_unit dut (
        .clock_i(clock), .reset_i(reset),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_read_data1_i(id_read_data1), .id_read_data2_i(id_read_data2),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
        .ex_reg_write_i(ex_reg_write), .ex_mem_read_i(ex_mem_read),
        .ex_read_data1_i(ex_read_data1), .ex_read_data2_i(ex_read_data2),
        .ex_alu_result_i(ex_alu_result), .mem_read_data_i(mem_read_data),
        .flush_i(flush),
        .alu_in_a_o(alu_in_a), .alu_in_b_o(alu_in_b),
        .id_op_a_o(id_op_a), .id_op_b_o(id_op_b),
        .stall_o(stall), .wb_reg_write_o(wb_reg_write), .wb_rd_o(wb_rd),
        .wb_data_o(wb_data), .stall_count_o(stall_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int unsigned rst, fl, id_rs, id_rt, id_d1, id_d2;
        int unsigned ex_rs, ex_rt, ex_rd, we, ld, ex_d1, ex_d2, res, mem;
        int unsigned e_a, e_b, e_ida, e_idb, e_stall, e_wbwe, e_wbrd, e_wbd, e_cnt;
    } vec_t;

    // Older instructions still in flight: entry 0 is one ahead of EX, entry 1 two ahead.
    typedef struct {
        int unsigned rd;
        bit          we;
        bit          ld;
        logic [31:0] val;
    } prod_t;

    prod_t hist[$];
    int unsigned mdl_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst[0];
        flush         = v.fl[0];
        id_rs         = 5'(v.id_rs);
        id_rt         = 5'(v.id_rt);
        id_read_data1 = v.id_d1;
        id_read_data2 = v.id_d2;
        ex_rs         = 5'(v.ex_rs);
        ex_rt         = 5'(v.ex_rt);
        ex_rd         = 5'(v.ex_rd);
        ex_reg_write  = v.we[0];
        ex_mem_read   = v.ld[0];
        ex_read_data1 = v.ex_d1;
        ex_read_data2 = v.ex_d2;
        ex_alu_result = v.res;
        mem_read_data = v.mem;
    endtask

    function automatic logic [31:0] mdl_fwd(input int unsigned src, input logic [31:0] raw);
        for (int d = 0; d < 2; d++) begin
            if (hist[d].we && hist[d].rd != 0 && hist[d].rd == src && !(d == 0 && hist[d].ld))
                return hist[d].val;
        end
        return raw;
    endfunction

    function automatic logic [31:0] mdl_byp(input int unsigned src, input logic [31:0] raw);
        if (hist[1].we && hist[1].rd != 0 && hist[1].rd == src) return hist[1].val;
        return raw;
    endfunction

    task automatic mdl_reset();
        hist = {};
        hist.push_back('{0, 1'b0, 1'b0, 32'd0});
        hist.push_back('{0, 1'b0, 1'b0, 32'd0});
        mdl_cnt = 0;
    endtask

    task automatic mdl_edge(input vec_t v, input bit st);
        if (v.rst != 0) begin
            mdl_reset();
        end else begin
            if (hist[0].ld) hist[0].val = v.mem;
            hist.push_front('{v.ex_rd, (v.we != 0) && (v.fl == 0), (v.ld != 0) && (v.fl == 0), v.res});
            void'(hist.pop_back());
            if (st && mdl_cnt < 65535) mdl_cnt++;
        end
    endtask

    vec_t tbl[20];
    vec_t rv;

    initial begin
        //            rst fl id_rs rt d1 d2 ex_rs rt rd we ld d1 d2 res mem | a b ida idb stall wbwe wbrd wbd cnt
        tbl[0]  = '{0,0, 0,0,3,4, 1,2,0,0,0, 1,2,0,0,              1,2,3,4, 0, 0,0,0, 0};
        tbl[1]  = '{0,0, 0,0,0,0, 0,0,3,1,0, 0,0,'h44,0,           0,0,0,0, 0, 0,0,0, 0};
        tbl[2]  = '{0,0, 0,0,0,0, 3,0,3,1,0, 'h11,0,'h33,0,        'h44,0,0,0, 0, 0,0,0, 0};
        tbl[3]  = '{0,0, 3,0,0,0, 0,3,0,0,0, 0,'h22,0,0,           0,'h33,'h44,0, 0, 1,3,'h44, 0};
        tbl[4]  = '{0,0, 0,0,0,0, 0,3,0,0,0, 0,'h22,0,0,           0,'h33,0,0, 0, 1,3,'h33, 0};
        tbl[5]  = '{0,0, 0,5,0,0, 0,0,5,1,1, 0,0,'h100,0,          0,0,0,0, 1, 0,0,0, 0};
        tbl[6]  = '{0,0, 0,5,0,0, 0,5,0,0,0, 0,'h55,0,'hDEAD,      0,'h55,0,0, 0, 0,0,0, 1};
        tbl[7]  = '{0,0, 0,0,0,0, 0,5,0,0,0, 0,0,0,0,              0,'hDEAD,0,0, 0, 1,5,'hDEAD, 1};
        tbl[8]  = '{0,0, 0,0,0,0, 0,0,0,1,0, 0,0,'hFF,0,           0,0,0,0, 0, 0,0,0, 1};
        tbl[9]  = '{0,0, 0,0,0,0, 0,0,0,1,1, 0,0,'h12,0,           0,0,0,0, 0, 0,0,0, 1};
        tbl[10] = '{0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,'h77,           0,0,0,0, 0, 1,0,'hFF, 1};
        tbl[11] = '{0,1, 0,0,0,0, 0,0,7,1,0, 0,0,'h70,0,           0,0,0,0, 0, 1,0,'h77, 1};
        tbl[12] = '{0,1, 6,0,0,0, 0,0,6,1,1, 0,0,'h60,0,           0,0,0,0, 0, 0,0,0, 1};
        tbl[13] = '{0,0, 0,0,0,0, 7,6,0,0,0, 5,9,0,0,              5,9,0,0, 0, 0,7,'h70, 1};
        tbl[14] = '{0,0, 0,8,0,0, 0,0,8,1,1, 0,0,'h88,0,           0,0,0,0, 1, 0,6,'h60, 1};
        tbl[15] = '{1,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,'h99,           0,0,0,0, 0, 0,0,0, 2};
        tbl[16] = '{0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,              0,0,0,0, 0, 0,0,0, 0};
        tbl[17] = '{0,0, 0,0,0,0, 0,0,9,1,0, 0,0,'hABCD,0,         0,0,0,0, 0, 0,0,0, 0};
        tbl[18] = '{0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,              0,0,0,0, 0, 0,0,0, 0};
        tbl[19] = '{0,0, 9,9,0,1, 0,0,0,0,0, 0,0,0,0,              0,0,'hABCD,'hABCD, 0, 1,9,'hABCD, 0};

        rv = tbl[16];
        rv.rst = 1;
        drive(rv);
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i]);
            #3;
            $display("[TB] row %0d a=%h b=%h ida=%h idb=%h stall=%0b wb=%0b/%0d/%h cnt=%0d",
                     i, alu_in_a, alu_in_b, id_op_a, id_op_b, stall, wb_reg_write, wb_rd, wb_data, stall_count);
            check($sformatf("row%0d alu_in_a", i), alu_in_a, tbl[i].e_a);
            check($sformatf("row%0d alu_in_b", i), alu_in_b, tbl[i].e_b);
            check($sformatf("row%0d id_op_a", i), id_op_a, tbl[i].e_ida);
            check($sformatf("row%0d id_op_b", i), id_op_b, tbl[i].e_idb);
            check($sformatf("row%0d stall", i), 32'(stall), tbl[i].e_stall);
            check($sformatf("row%0d wb_reg_write", i), 32'(wb_reg_write), tbl[i].e_wbwe);
            check($sformatf("row%0d wb_rd", i), 32'(wb_rd), tbl[i].e_wbrd);
            check($sformatf("row%0d wb_data", i), wb_data, tbl[i].e_wbd);
            check($sformatf("row%0d stall_count", i), 32'(stall_count), tbl[i].e_cnt);
            @(posedge clock);
            #1;
        end

        // Randomized run against the in-flight producer model.
        rv = tbl[16];
        rv.rst = 1;
        drive(rv);
        @(posedge clock);
        #1;
        mdl_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] ea, eb, eia, eib;
            bit          est;
            rv.rst   = ($urandom_range(0, 63) == 0) ? 1 : 0;
            rv.fl    = ($urandom_range(0, 7) == 0) ? 1 : 0;
            rv.id_rs = $urandom_range(0, 7);
            rv.id_rt = $urandom_range(0, 7);
            rv.id_d1 = $urandom;
            rv.id_d2 = $urandom;
            rv.ex_rs = $urandom_range(0, 7);
            rv.ex_rt = $urandom_range(0, 7);
            rv.ex_rd = $urandom_range(0, 7);
            rv.we    = ($urandom_range(0, 3) != 0) ? 1 : 0;
            rv.ld    = ($urandom_range(0, 2) == 0) ? 1 : 0;
            rv.ex_d1 = $urandom;
            rv.ex_d2 = $urandom;
            rv.res   = $urandom;
            rv.mem   = $urandom;
            drive(rv);
            #3;
            ea  = mdl_fwd(rv.ex_rs, rv.ex_d1);
            eb  = mdl_fwd(rv.ex_rt, rv.ex_d2);
            eia = mdl_byp(rv.id_rs, rv.id_d1);
            eib = mdl_byp(rv.id_rt, rv.id_d2);
            est = rv.ld != 0 && rv.we != 0 && rv.ex_rd != 0 && rv.fl == 0
                  && (rv.ex_rd == rv.id_rs || rv.ex_rd == rv.id_rt);
            $display("[TB] rnd %0d a=%h b=%h stall=%0b wb=%0b/%0d/%h cnt=%0d",
                     c, alu_in_a, alu_in_b, stall, wb_reg_write, wb_rd, wb_data, stall_count);
            check($sformatf("rnd%0d alu_in_a", c), alu_in_a, ea);
            check($sformatf("rnd%0d alu_in_b", c), alu_in_b, eb);
            check($sformatf("rnd%0d id_op_a", c), id_op_a, eia);
            check($sformatf("rnd%0d id_op_b", c), id_op_b, eib);
            check($sformatf("rnd%0d stall", c), 32'(stall), 32'(est));
            check($sformatf("rnd%0d wb_reg_write", c), 32'(wb_reg_write), 32'(hist[1].we));
            check($sformatf("rnd%0d wb_rd", c), 32'(wb_rd), hist[1].rd);
            check($sformatf("rnd%0d wb_data", c), wb_data, hist[1].val);
            check($sformatf("rnd%0d stall_count", c), 32'(stall_count), mdl_cnt);
            mdl_edge(rv, est);
            @(posedge clock);
            #1;
        end

        // Saturation: hold a load-use pair until the counter pins at FFFF.
        rv = tbl[16];
        rv.rst = 1;
        drive(rv);
        @(posedge clock);
        #1;
        rv = tbl[5];
        drive(rv);
        repeat (65534) @(posedge clock);
        #1;
        $display("[TB] sat cnt=%0d after 65534 stall cycles", stall_count);
        check("sat below max", 32'(stall_count), 32'hFFFE);
        @(posedge clock);
        #1;
        $display("[TB] sat cnt=%0d after 65535 stall cycles", stall_count);
        check("sat reach max", 32'(stall_count), 32'hFFFF);
        repeat (4465) @(posedge clock);
        #1;
        $display("[TB] sat cnt=%0d after 70000 stall cycles", stall_count);
        check("sat hold max", 32'(stall_count), 32'hFFFF);
        check("sat stall held", 32'(stall), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
